mod_pow_ctrl_secp256k1: RTL and testbench

//  Initiator-side sequencer for the secp256k1 field units. Computes Z = A^EXP mod P by

---
 rtl/secp256k1_pkg.sv | 25 ++
 rtl/mod_pow_ctrl_secp256k1.sv | 139 +++++++++++++
 tb/tb_mod_pow_ctrl_secp256k1.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secp256k1_pkg.sv
// Shared constants and types for the secp256k1 field sequencers.
package secp256k1_pkg;

  // Field prime P = 2^256 - 2^32 - 977
  localparam logic [255:0] P_CONST      = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  // Exponent for field inversion (Fermat)
  localparam logic [255:0] P_MINUS_2    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;
  // Exponent for square root (P == 3 mod 4)
  localparam logic [255:0] P_PLUS1_DIV4 = 256'h3FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_BFFFFF0C;
  // 2^256 mod P, used by the reduction units
  localparam logic [255:0] K_VAL        = 256'h00000000_00000000_00000000_00000000_00000000_00000000_00000001_000003D1;

  // Exponent bit index width
  localparam int IDX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SQ_REQ,
    SQ_WAIT,
    MUL_REQ,
    MUL_WAIT,
    FINISH
  } pow_state_t;

endpackage

// File: rtl/mod_pow_ctrl_secp256k1.sv
// Left-to-right square-and-multiply sequencer: Z = A^EXP mod P.
// Drives an external squarer and multiplier over start/done handshakes.
import secp256k1_pkg::*;

module mod_pow_ctrl_secp256k1 #(
  parameter logic [255:0] EXP      = P_MINUS_2,
  parameter int           EXP_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] A,
  output logic [255:0] Z,
  output logic         done,
  output logic         busy,
  output logic         zero_err,
  output logic         sq_start,
  output logic [255:0] sq_a,
  input  logic [255:0] sq_z,
  input  logic         sq_done,
  output logic         mul_start,
  output logic [255:0] mul_a,
  output logic [255:0] mul_b,
  input  logic [255:0] mul_z,
  input  logic         mul_done
);

  // Exponent must be normalised: its top significant bit is the implicit initial acc=A.
  if (EXP_BITS < 1 || EXP_BITS > 256) begin : g_bits_range
    $error("EXP_BITS must be in 1..256");
  end else if (EXP[EXP_BITS-1] !== 1'b1) begin : g_bits_msb
    $error("EXP[EXP_BITS-1] must be 1");
  end

  localparam logic [IDX_W-1:0] IDX_INIT = (EXP_BITS >= 2) ? IDX_W'(EXP_BITS - 2) : '0;
  localparam bit               ONE_BIT  = (EXP_BITS == 1);

  pow_state_t       state, state_d;
  logic [255:0]     acc, base;
  logic [IDX_W-1:0] idx;
  logic             exp_bit, idx_zero, accept;

  assign exp_bit  = EXP[idx];
  assign idx_zero = (idx == '0);

  // Operands come straight from flops, so they stay put for the whole sub-unit call.
  assign sq_a  = acc;
  assign mul_a = acc;
  assign mul_b = base;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and sub-unit request strobes
  always_comb begin
    state_d   = state;
    sq_start  = 1'b0;
    mul_start = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (A == '0 || ONE_BIT) ? FINISH : SQ_REQ;
        end
      end
      SQ_REQ: begin
        sq_start = 1'b1;
        state_d  = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (sq_done) begin
          if (exp_bit)       state_d = MUL_REQ;
          else if (idx_zero) state_d = FINISH;
          else               state_d = SQ_REQ;
        end
      end
      MUL_REQ: begin
        mul_start = 1'b1;
        state_d   = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done) state_d = idx_zero ? FINISH : SQ_REQ;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, captured base, bit index and result/status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      base     <= '0;
      idx      <= '0;
      Z        <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            base     <= A;
            acc      <= A;
            idx      <= IDX_INIT;
            zero_err <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SQ_WAIT: begin
          if (sq_done) begin
            acc <= sq_z;
            // Index only moves on when this bit needs no multiply.
            if (!exp_bit && !idx_zero) idx <= idx - 1'b1;
          end
        end
        MUL_WAIT: begin
          if (mul_done) begin
            acc <= mul_z;
            if (!idx_zero) idx <= idx - 1'b1;
          end
        end
        FINISH: begin
          Z        <= (base == '0) ? '0 : acc;
          zero_err <= (base == '0);
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_pow_ctrl_secp256k1.sv
// Bench for mod_pow_ctrl_secp256k1: inversion and sqrt instances with behavioural sub-units.
module tb_mod_pow_ctrl_secp256k1;
  import secp256k1_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        start_v = '0;
  logic [1:0][255:0] a_v = '0;
  logic [1:0][255:0] z_v;
  logic [1:0]        done_v, busy_v, zerr_v, sqs_v, muls_v;
  logic [1:0][31:0]  nsq_v, nmul_v, nstab_v;

  int sq_lat   = 2;
  int mul_lat  = 1;
  bit mul_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] p;
    p = {256'd0, a} * {256'd0, b};
    p = p % {256'd0, P_CONST};
    return p[255:0];
  endfunction

  // Right-to-left binary exponentiation over the low nbits of e
  function automatic logic [255:0] modpow(input logic [255:0] a, input logic [255:0] e, input int nbits);
    logic [255:0] r, b;
    r = 256'd1;
    b = a;
    for (int i = 0; i < nbits; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] a;
    a = '0;
    while (a == '0 || a >= P_CONST) begin
      for (int i = 0; i < 8; i++) a[i*32 +: 32] = $urandom;
    end
    return a;
  endfunction

  // Instance 0 inverts, instance 1 takes square roots
  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam logic [255:0] E  = (g == 0) ? P_MINUS_2 : P_PLUS1_DIV4;
    localparam int           EB = (g == 0) ? 256 : 254;

    logic         sq_start, sq_done = 1'b0, mul_start, mul_done = 1'b0;
    logic [255:0] sq_a, mul_a, mul_b;
    logic [255:0] sq_z = '0, mul_z = '0;
    logic [255:0] sq_op = '0, ma_op = '0, mb_op = '0;
    logic         sq_act = 1'b0, mul_act = 1'b0;
    int           sq_cnt = 0, mul_cnt = 0, nxt_lat = 1;
    logic [31:0]  n_sq = 0, n_mul = 0, n_stab_sq = 0, n_stab_mul = 0;

    mod_pow_ctrl_secp256k1 #(.EXP(E), .EXP_BITS(EB)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .A(a_v[g]), .Z(z_v[g]),
      .done(done_v[g]), .busy(busy_v[g]), .zero_err(zerr_v[g]),
      .sq_start(sq_start), .sq_a(sq_a), .sq_z(sq_z), .sq_done(sq_done),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_done(mul_done)
    );

    assign sqs_v[g]   = sq_start;
    assign muls_v[g]  = mul_start;
    assign nsq_v[g]   = n_sq;
    assign nmul_v[g]  = n_mul;
    assign nstab_v[g] = n_stab_sq + n_stab_mul;

    // Request counters
    always @(posedge clk) begin
      if (sq_start)  n_sq  <= n_sq + 1;
      if (mul_start) n_mul <= n_mul + 1;
    end

    // Squarer: reads its operand every cycle, result from the operand at completion
    always @(posedge clk) begin
      if (!rst_n) begin
        sq_act  <= 1'b0;
        sq_done <= 1'b0;
      end else begin
        sq_done <= 1'b0;
        if (sq_act) begin
          if (sq_a !== sq_op) n_stab_sq <= n_stab_sq + 1;
          if (sq_cnt <= 1) begin
            sq_done <= 1'b1;
            sq_z    <= mulmod(sq_a, sq_a);
            sq_act  <= 1'b0;
          end else sq_cnt <= sq_cnt - 1;
        end else if (sq_start) begin
          if (sq_lat <= 1) begin
            sq_done <= 1'b1;
            sq_z    <= mulmod(sq_a, sq_a);
          end else begin
            sq_act <= 1'b1;
            sq_op  <= sq_a;
            sq_cnt <= sq_lat - 1;
          end
        end
      end
    end

    // Multiplier with fixed or per-call random latency
    always @(posedge clk) begin
      nxt_lat <= mul_rand ? int'($urandom_range(80, 1)) : mul_lat;
      if (!rst_n) begin
        mul_act  <= 1'b0;
        mul_done <= 1'b0;
      end else begin
        mul_done <= 1'b0;
        if (mul_act) begin
          if (mul_a !== ma_op || mul_b !== mb_op) n_stab_mul <= n_stab_mul + 1;
          if (mul_cnt <= 1) begin
            mul_done <= 1'b1;
            mul_z    <= mulmod(mul_a, mul_b);
            mul_act  <= 1'b0;
          end else mul_cnt <= mul_cnt - 1;
        end else if (mul_start) begin
          if (nxt_lat <= 1) begin
            mul_done <= 1'b1;
            mul_z    <= mulmod(mul_a, mul_b);
          end else begin
            mul_act <= 1'b1;
            ma_op   <= mul_a;
            mb_op   <= mul_b;
            mul_cnt <= nxt_lat - 1;
          end
        end
      end
    end
  end

  task automatic launch(input int g, input logic [255:0] a);
    @(negedge clk);
    a_v[g]     = a;
    start_v[g] = 1'b1;
  endtask

  task automatic wait_done(input int g, input int budget, output int cyc, output bit to);
    bit seen;
    cyc  = 0;
    to   = 1'b0;
    seen = 1'b0;
    while (!seen && !to) begin
      @(negedge clk);
      start_v[g] = 1'b0;
      cyc++;
      if (done_v[g]) seen = 1'b1;
      else if (cyc >= budget) to = 1'b1;
    end
  endtask

  task automatic run_op(input int g, input logic [255:0] a, input int budget,
                        output logic [255:0] z, output logic zerr, output int cyc, output bit to);
    launch(g, a);
    wait_done(g, budget, cyc, to);
    z    = z_v[g];
    zerr = zerr_v[g];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (z_v[0] !== '0)    begin errors++; $display("FAIL reset_z: got %h want 0", z_v[0]); end
    checks++; if (z_v[1] !== '0)    begin errors++; $display("FAIL reset_z_sqrt: got %h want 0", z_v[1]); end
    checks++; if (done_v !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done_v); end
    checks++; if (busy_v !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", busy_v); end
    checks++; if (zerr_v !== 2'b00) begin errors++; $display("FAIL reset_zero_err: got %b want 00", zerr_v); end
    checks++; if (sqs_v !== 2'b00 || muls_v !== 2'b00)
      begin errors++; $display("FAIL reset_starts: got sq=%b mul=%b want 00", sqs_v, muls_v); end
  endtask

  task automatic test_one();
    logic [255:0] z; logic ze; int cyc; bit to; logic [31:0] s0, m0;
    sq_lat = 67; mul_lat = 3;
    s0 = nsq_v[0]; m0 = nmul_v[0];
    run_op(0, 256'd1, 30000, z, ze, cyc, to);
    checks++; if (to !== 1'b0)  begin errors++; $display("FAIL one_timeout: got %0d cycles, no done", cyc); end
    checks++; if (z !== 256'd1) begin errors++; $display("FAIL one_z: got %h want 1", z); end
    checks++; if (ze !== 1'b0)  begin errors++; $display("FAIL one_zero_err: got %b want 0", ze); end
    checks++; if (nsq_v[0] - s0 !== 32'd255)
      begin errors++; $display("FAIL one_sq_count: got %0d want 255", nsq_v[0] - s0); end
    checks++; if (nmul_v[0] - m0 !== 32'd248)
      begin errors++; $display("FAIL one_mul_count: got %0d want 248", nmul_v[0] - m0); end
    checks++; if (cyc != 2 + 255 * 68 + 248 * 4)
      begin errors++; $display("FAIL one_latency: got %0d want %0d", cyc, 2 + 255 * 68 + 248 * 4); end
    sq_lat = 2; mul_lat = 1;
  endtask

  task automatic test_two();
    logic [255:0] z, want; logic ze; int cyc; bit to;
    want = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;
    run_op(0, 256'd2, 5000, z, ze, cyc, to);
    checks++; if (z !== want) begin errors++; $display("FAIL two_z: got %h want %h", z, want); end
    checks++; if (mulmod(256'd2, z) !== 256'd1)
      begin errors++; $display("FAIL two_inverse: got 2*Z=%h want 1", mulmod(256'd2, z)); end
    checks++; if (cyc != 2 + 255 * 3 + 248 * 2)
      begin errors++; $display("FAIL two_latency: got %0d want %0d", cyc, 2 + 255 * 3 + 248 * 2); end
  endtask

  task automatic test_pm1();
    logic [255:0] z, pm1; logic ze; int cyc; bit to;
    pm1 = P_CONST - 256'd1;
    run_op(0, pm1, 5000, z, ze, cyc, to);
    checks++; if (z !== pm1) begin errors++; $display("FAIL pm1_z: got %h want %h", z, pm1); end
  endtask

  task automatic test_random();
    logic [255:0] a, z, want; logic ze; int cyc; bit to;
    for (int i = 0; i < 4; i++) begin
      a = rand_fe();
      want = modpow(a, P_MINUS_2, 256);
      run_op(0, a, 5000, z, ze, cyc, to);
      checks++; if (z !== want) begin errors++; $display("FAIL rand_z[%0d]: A=%h got %h want %h", i, a, z, want); end
      checks++; if (mulmod(a, z) !== 256'd1)
        begin errors++; $display("FAIL rand_inverse[%0d]: got A*Z=%h want 1", i, mulmod(a, z)); end
      checks++; if (ze !== 1'b0) begin errors++; $display("FAIL rand_zero_err[%0d]: got %b want 0", i, ze); end
    end
  endtask

  task automatic test_zero();
    logic [255:0] z; logic ze; int cyc; bit to; logic [31:0] s0, m0;
    s0 = nsq_v[0]; m0 = nmul_v[0];
    run_op(0, 256'd0, 50, z, ze, cyc, to);
    checks++; if (z !== '0)   begin errors++; $display("FAIL zero_z: got %h want 0", z); end
    checks++; if (ze !== 1'b1) begin errors++; $display("FAIL zero_err_flag: got %b want 1", ze); end
    checks++; if (cyc != 2)   begin errors++; $display("FAIL zero_latency: got %0d want 2", cyc); end
    checks++; if (nsq_v[0] !== s0 || nmul_v[0] !== m0)
      begin errors++; $display("FAIL zero_no_requests: got sq=%0d mul=%0d want 0 0", nsq_v[0] - s0, nmul_v[0] - m0); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a1, a3, z; logic ze; int cyc; bit to;
    a1 = rand_fe(); a3 = rand_fe();
    run_op(0, a1, 5000, z, ze, cyc, to);
    checks++; if (z !== modpow(a1, P_MINUS_2, 256)) begin errors++; $display("FAIL b2b_first: got %h", z); end
    run_op(0, 256'd0, 50, z, ze, cyc, to);
    checks++; if (z !== '0 || ze !== 1'b1) begin errors++; $display("FAIL b2b_zero: got Z=%h err=%b want 0 1", z, ze); end
    run_op(0, a3, 5000, z, ze, cyc, to);
    checks++; if (z !== modpow(a3, P_MINUS_2, 256)) begin errors++; $display("FAIL b2b_third: got %h", z); end
    checks++; if (ze !== 1'b0) begin errors++; $display("FAIL b2b_err_cleared: got %b want 0", ze); end
  endtask

  task automatic test_start_midop();
    logic [255:0] a1, a2, want; int cyc; bit to; logic [31:0] s0;
    a1 = rand_fe(); a2 = rand_fe();
    want = modpow(a1, P_MINUS_2, 256);
    s0 = nsq_v[0];
    launch(0, a1);
    repeat (30) begin @(negedge clk); start_v[0] = 1'b0; end
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", busy_v[0]); end
    a_v[0] = a2; start_v[0] = 1'b1;
    wait_done(0, 5000, cyc, to);
    checks++; if (z_v[0] !== want) begin errors++; $display("FAIL midop_z: got %h want %h", z_v[0], want); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL midop_busy_at_done: got %b want 0", busy_v[0]); end
    checks++; if (nsq_v[0] - s0 !== 32'd255)
      begin errors++; $display("FAIL midop_sq_count: got %0d want 255", nsq_v[0] - s0); end
  endtask

  task automatic test_reset_midop();
    logic [255:0] a1, a2, z; logic ze; int cyc, nd; bit to; logic [31:0] s0;
    a1 = rand_fe(); a2 = rand_fe();
    launch(0, a1);
    repeat (300) begin @(negedge clk); start_v[0] = 1'b0; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s0 = nsq_v[0];
    nd = 0;
    repeat (20) begin @(negedge clk); if (done_v[0]) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses want 0", nd); end
    checks++; if (busy_v[0] !== 1'b0 || z_v[0] !== '0)
      begin errors++; $display("FAIL rstmid_idle: got busy=%b Z=%h want 0 0", busy_v[0], z_v[0]); end
    checks++; if (nsq_v[0] !== s0) begin errors++; $display("FAIL rstmid_sq_idle: got %0d requests want 0", nsq_v[0] - s0); end
    run_op(0, a2, 5000, z, ze, cyc, to);
    checks++; if (z !== modpow(a2, P_MINUS_2, 256)) begin errors++; $display("FAIL rstmid_next: got %h", z); end
    checks++; if (cyc != 2 + 255 * 3 + 248 * 2)
      begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", cyc, 2 + 255 * 3 + 248 * 2); end
  endtask

  task automatic test_sqrt();
    logic [255:0] a, r, z, want; logic ze; int cyc; bit to; logic [31:0] m0;
    mul_rand = 1'b1;
    m0 = nmul_v[1];
    run_op(1, 256'd4, 25000, z, ze, cyc, to);
    checks++; if (to !== 1'b0)  begin errors++; $display("FAIL sqrt4_timeout: got %0d cycles, no done", cyc); end
    checks++; if (z !== 256'd2) begin errors++; $display("FAIL sqrt4_z: got %h want 2", z); end
    checks++; if (nmul_v[1] - m0 != 32'($countones(P_PLUS1_DIV4) - 1))
      begin errors++; $display("FAIL sqrt4_mul_count: got %0d want %0d", nmul_v[1] - m0, $countones(P_PLUS1_DIV4) - 1); end
    r = rand_fe();
    a = mulmod(r, r);
    want = modpow(a, P_PLUS1_DIV4, 254);
    run_op(1, a, 25000, z, ze, cyc, to);
    checks++; if (z !== want) begin errors++; $display("FAIL sqrt_rand_z: got %h want %h", z, want); end
    checks++; if (mulmod(z, z) !== a) begin errors++; $display("FAIL sqrt_rand_square: got Z^2=%h want %h", mulmod(z, z), a); end
    mul_rand = 1'b0;
    checks++; if (nstab_v[0] !== 32'd0 || nstab_v[1] !== 32'd0)
      begin errors++; $display("FAIL operand_stable: got %0d/%0d changes want 0", nstab_v[0], nstab_v[1]); end
  endtask

  initial begin
    test_reset();
    test_one();
    test_two();
    test_pm1();
    test_random();
    test_zero();
    test_back_to_back();
    test_start_midop();
    test_reset_midop();
    test_sqrt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
